// File: rtl/big_fv_bank_arbiter.sv
// Per-bank round-robin arbiter steering Edge PE feature-vector requests to Big FV banks.
// Write streams (sos..eos) hold their bank until the owner's eos beat is granted.
module big_fv_bank_arbiter #(
    parameter int NUM_PE    = 4,
    parameter int NUM_BANKS = 4,
    parameter int FV_BW     = 16,
    parameter int NODE_W    = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PE-1:0]               pe_valid,
    input  logic [NUM_PE-1:0]               pe_rd_wr,
    input  logic [NUM_PE*NODE_W-1:0]        pe_node_id,
    input  logic [NUM_PE*FV_BW-1:0]         pe_data,
    input  logic [NUM_PE-1:0]               pe_wr_sos,
    input  logic [NUM_PE-1:0]               pe_wr_eos,
    output logic [NUM_PE-1:0]               pe_ready,
    input  logic [NUM_BANKS-1:0]            bank_available,
    output logic [NUM_BANKS-1:0]            bank_valid,
    output logic [NUM_BANKS*((NUM_PE > 1) ? $clog2(NUM_PE) : 1)-1:0] bank_pe_tag,
    output logic [NUM_BANKS-1:0]            bank_rd_wr,
    output logic [NUM_BANKS-1:0]            bank_wr_sos,
    output logic [NUM_BANKS-1:0]            bank_wr_eos,
    output logic [NUM_BANKS*NODE_W-1:0]     bank_node_id,
    output logic [NUM_BANKS*FV_BW-1:0]      bank_data
);

    localparam int PE_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state [NUM_BANKS];
    logic [PE_W-1:0]   owner [NUM_BANKS];
    logic [PE_W-1:0]   rr    [NUM_BANKS];

    logic [BANK_W-1:0] tgt          [NUM_PE];
    logic [NUM_PE-1:0] elig         [NUM_BANKS];
    logic [NUM_BANKS-1:0] gnt_any_p0;
    logic [PE_W-1:0]   gnt_pe_p0    [NUM_BANKS];
    logic [NODE_W-1:0] sel_node_p0  [NUM_BANKS];
    logic [FV_BW-1:0]  sel_data_p0  [NUM_BANKS];
    logic [NUM_BANKS-1:0] sel_rw_p0;
    logic [NUM_BANKS-1:0] sel_sos_p0;
    logic [NUM_BANKS-1:0] sel_eos_p0;
    logic [NUM_PE-1:0] ready_c;

    always_comb begin
        for (int p = 0; p < NUM_PE; p++) begin
            tgt[p] = pe_node_id[p*NODE_W +: BANK_W];
        end
    end

    // Stage p0: eligibility, round-robin search from rr[b], and field selection
    always_comb begin
        ready_c = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt_any_p0[b]  = 1'b0;
            gnt_pe_p0[b]   = '0;
            sel_node_p0[b] = '0;
            sel_data_p0[b] = '0;
            sel_rw_p0[b]   = 1'b0;
            sel_sos_p0[b]  = 1'b0;
            sel_eos_p0[b]  = 1'b0;
            for (int p = 0; p < NUM_PE; p++) begin
                elig[b][p] = !reset && pe_valid[p] && bank_available[b]
                             && (tgt[p] == BANK_W'(b))
                             && ((state[b] == IDLE) || (owner[b] == PE_W'(p)));
            end
            for (int i = 0; i < NUM_PE; i++) begin
                if (!gnt_any_p0[b] && elig[b][rr[b] + PE_W'(i)]) begin
                    gnt_any_p0[b] = 1'b1;
                    gnt_pe_p0[b]  = rr[b] + PE_W'(i);
                end
            end
            if (gnt_any_p0[b]) begin
                ready_c[gnt_pe_p0[b]] = 1'b1;
                sel_node_p0[b] = pe_node_id[gnt_pe_p0[b]*NODE_W +: NODE_W];
                sel_data_p0[b] = pe_data[gnt_pe_p0[b]*FV_BW +: FV_BW];
                sel_rw_p0[b]   = pe_rd_wr[gnt_pe_p0[b]];
                // Stream markers only carry meaning on writes.
                sel_sos_p0[b]  = pe_rd_wr[gnt_pe_p0[b]] & pe_wr_sos[gnt_pe_p0[b]];
                sel_eos_p0[b]  = pe_rd_wr[gnt_pe_p0[b]] & pe_wr_eos[gnt_pe_p0[b]];
            end
        end
    end

    assign pe_ready = ready_c;

    // Stage p1: registered packet, lock FSM and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state[b] <= IDLE;
                owner[b] <= '0;
                rr[b]    <= '0;
            end
            bank_valid   <= '0;
            bank_pe_tag  <= '0;
            bank_rd_wr   <= '0;
            bank_wr_sos  <= '0;
            bank_wr_eos  <= '0;
            bank_node_id <= '0;
            bank_data    <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_valid[b] <= gnt_any_p0[b];
                if (gnt_any_p0[b]) begin
                    bank_pe_tag[b*PE_W +: PE_W]     <= gnt_pe_p0[b];
                    bank_node_id[b*NODE_W +: NODE_W] <= sel_node_p0[b];
                    bank_data[b*FV_BW +: FV_BW]     <= sel_data_p0[b];
                    bank_rd_wr[b]                   <= sel_rw_p0[b];
                    bank_wr_sos[b]                  <= sel_sos_p0[b];
                    bank_wr_eos[b]                  <= sel_eos_p0[b];
                    rr[b]                           <= gnt_pe_p0[b] + PE_W'(1);
                    case (state[b])
                        IDLE: begin
                            if (sel_sos_p0[b] && !sel_eos_p0[b]) begin
                                state[b] <= LOCKED;
                                owner[b] <= gnt_pe_p0[b];
                            end
                        end
                        LOCKED: begin
                            if (sel_eos_p0[b]) begin
                                state[b] <= IDLE;
                            end
                        end
                        default: state[b] <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_big_fv_bank_arbiter.sv
// Table-driven bench for big_fv_bank_arbiter: per-cycle vectors with hand-chosen grants,
// expected bank packets queued at drive time and compared one cycle later.
module tb_big_fv_bank_arbiter;

    localparam int NP = 4;
    localparam int NB = 4;
    localparam int FW = 16;
    localparam int NW = 10;
    localparam int TW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     pe_valid, pe_rd_wr, pe_wr_sos, pe_wr_eos, pe_ready;
    logic [NP*NW-1:0]  pe_node_id;
    logic [NP*FW-1:0]  pe_data;
    logic [NB-1:0]     bank_available, bank_valid, bank_rd_wr, bank_wr_sos, bank_wr_eos;
    logic [NB*TW-1:0]  bank_pe_tag;
    logic [NB*NW-1:0]  bank_node_id;
    logic [NB*FW-1:0]  bank_data;

    always #5 clk = ~clk;

    big_fv_bank_arbiter #(.NUM_PE(NP), .NUM_BANKS(NB), .FV_BW(FW), .NODE_W(NW)) dut (
        .clk(clk), .reset(reset),
        .pe_valid(pe_valid), .pe_rd_wr(pe_rd_wr), .pe_node_id(pe_node_id), .pe_data(pe_data),
        .pe_wr_sos(pe_wr_sos), .pe_wr_eos(pe_wr_eos), .pe_ready(pe_ready),
        .bank_available(bank_available), .bank_valid(bank_valid), .bank_pe_tag(bank_pe_tag),
        .bank_rd_wr(bank_rd_wr), .bank_wr_sos(bank_wr_sos), .bank_wr_eos(bank_wr_eos),
        .bank_node_id(bank_node_id), .bank_data(bank_data)
    );

    typedef struct {
        bit            rst;
        logic [NP-1:0] valid, rd_wr, sos, eos;
        logic [NP*NW-1:0] node;
        logic [NP*FW-1:0] data;
        logic [NB-1:0] avail;
        logic [NP-1:0] exp_ready;
    } vec_t;

    typedef struct {
        bit            rst;
        logic [NB-1:0] valid, rw, sos, eos;
        logic [NB*TW-1:0] tag;
        logic [NB*NW-1:0] node;
        logic [NB*FW-1:0] data;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t blank();
        vec_t v;
        v.rst = 1'b0; v.valid = '0; v.rd_wr = '0; v.sos = '0; v.eos = '0;
        v.node = '0; v.data = '0; v.avail = '1; v.exp_ready = '0;
        return v;
    endfunction

    function automatic vec_t add(vec_t v, int p, bit rw, bit s, bit e, int nd, logic [FW-1:0] d);
        v.valid[p] = 1'b1; v.rd_wr[p] = rw; v.sos[p] = s; v.eos[p] = e;
        v.node[p*NW +: NW] = NW'(nd);
        v.data[p*FW +: FW] = d;
        return v;
    endfunction

    task automatic push(input vec_t v, input logic [NP-1:0] r);
        v.exp_ready = r;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        int   b;
        logic [30:0] got, want;
        reset = v.rst; pe_valid = v.valid; pe_rd_wr = v.rd_wr; pe_wr_sos = v.sos;
        pe_wr_eos = v.eos; pe_node_id = v.node; pe_data = v.data; bank_available = v.avail;
        #2;
        checks++;
        if (pe_ready !== v.exp_ready) begin
            errors++;
            $display("FAIL pe_ready step %0d: got %b want %b", idx, pe_ready, v.exp_ready);
        end
        e.rst = v.rst; e.valid = '0; e.rw = '0; e.sos = '0; e.eos = '0;
        e.tag = '0; e.node = '0; e.data = '0;
        if (!v.rst) begin
            for (int p = 0; p < NP; p++) begin
                if (v.exp_ready[p]) begin
                    b = int'(v.node[p*NW +: 2]);
                    e.valid[b] = 1'b1;
                    e.tag[b*TW +: TW] = TW'(p);
                    e.node[b*NW +: NW] = v.node[p*NW +: NW];
                    e.data[b*FW +: FW] = v.data[p*FW +: FW];
                    e.rw[b]  = v.rd_wr[p];
                    e.sos[b] = v.rd_wr[p] & v.sos[p];
                    e.eos[b] = v.rd_wr[p] & v.eos[p];
                end
            end
        end
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        if (e.rst) begin
            checks++;
            if ((|bank_valid) || (|bank_pe_tag) || (|bank_rd_wr) || (|bank_wr_sos) ||
                (|bank_wr_eos) || (|bank_node_id) || (|bank_data)) begin
                errors++;
                $display("FAIL reset_outputs step %0d: valid %b tag %h node %h data %h, all want 0",
                         idx, bank_valid, bank_pe_tag, bank_node_id, bank_data);
            end
        end else begin
            checks++;
            if (bank_valid !== e.valid) begin
                errors++;
                $display("FAIL bank_valid step %0d: got %b want %b", idx, bank_valid, e.valid);
            end
            for (int k = 0; k < NB; k++) begin
                if (e.valid[k]) begin
                    got  = {bank_pe_tag[k*TW +: TW], bank_node_id[k*NW +: NW], bank_data[k*FW +: FW],
                            bank_rd_wr[k], bank_wr_sos[k], bank_wr_eos[k]};
                    want = {e.tag[k*TW +: TW], e.node[k*NW +: NW], e.data[k*FW +: FW],
                            e.rw[k], e.sos[k], e.eos[k]};
                    checks++;
                    if (got !== want) begin
                        errors++;
                        $display("FAIL packet bank%0d step %0d: got %h want %h (tag,node,data,rw,sos,eos)",
                                 k, idx, got, want);
                    end
                end
            end
        end
    endtask

    initial begin
        vec_t v, w;
        reset = 1'b1; pe_valid = '0; pe_rd_wr = '0; pe_wr_sos = '0; pe_wr_eos = '0;
        pe_node_id = '0; pe_data = '0; bank_available = '1;

        // Reset held with a live request: no ready, all outputs cleared.
        v = blank(); v.rst = 1'b1; v = add(v, 0, 0, 0, 0, 5, 16'h1111);
        push(v, 4'b0000); push(v, 4'b0000);
        // Single read PE0 -> node 5 (bank 1).
        v.rst = 1'b0; push(v, 4'b0001);
        push(blank(), 4'b0000);
        // Four PEs reading bank 0 continuously: round-robin 0,1,2,3,0.
        v = blank();
        for (int p = 0; p < NP; p++) v = add(v, p, 0, 0, 0, p*4, 16'h2000 + 16'(p));
        push(v, 4'b0001); push(v, 4'b0010); push(v, 4'b0100); push(v, 4'b1000); push(v, 4'b0001);
        push(blank(), 4'b0000);
        // Prime rr[3]=2 with a PE1 read of node 3.
        v = add(blank(), 1, 0, 0, 0, 3, 16'h3333); push(v, 4'b0010);
        // PE2 and PE1 both open a stream on bank 3; PE2 wins and locks.
        w = add(blank(), 1, 1, 1, 0, 3, 16'hD000);
        v = add(w, 2, 1, 1, 0, 7, 16'hC000); push(v, 4'b0100);
        // Mid beat from the owner, plus an unrelated bank-1 read in the same cycle.
        v = add(w, 2, 1, 0, 0, 7, 16'hC001); v = add(v, 0, 0, 0, 0, 1, 16'h0E01); push(v, 4'b0101);
        // Bank 3 stalled for three cycles with the eos beat pending.
        v = add(w, 2, 1, 0, 1, 7, 16'hC002); v.avail = 4'b0111;
        push(v, 4'b0000); push(v, 4'b0000); push(v, 4'b0000);
        v.avail = 4'b1111; push(v, 4'b0100);
        // Lock released: PE1's waiting stream now starts and completes.
        push(w, 4'b0010);
        v = add(blank(), 1, 1, 0, 1, 3, 16'hD001); push(v, 4'b0010);
        push(blank(), 4'b0000);
        // Single-beat write does not lock; read markers are dropped and do not lock.
        v = add(blank(), 1, 1, 1, 1, 2, 16'h5A5A); push(v, 4'b0010);
        v = add(blank(), 0, 0, 1, 1, 6, 16'h6666); push(v, 4'b0001);
        v = add(blank(), 3, 0, 0, 0, 2, 16'h7777); push(v, 4'b1000);
        push(blank(), 4'b0000);
        // PE3 locks bank 0, PE1 waits; reset mid-stream clears the lock.
        v = add(blank(), 3, 1, 1, 0, 4, 16'hE000); push(v, 4'b1000);
        v = add(blank(), 3, 1, 0, 0, 4, 16'hE001); v = add(v, 1, 1, 1, 0, 8, 16'hF000);
        push(v, 4'b1000);
        v.rst = 1'b1; push(v, 4'b0000);
        v.rst = 1'b0; push(v, 4'b0010);
        v = add(blank(), 1, 1, 0, 1, 8, 16'hF001); push(v, 4'b0010);
        push(blank(), 4'b0000);

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
